// File: rtl/seq_shift_mult.sv
// seq_shift_mult: iterative shift-and-add unsigned multiplier with a
// start/busy/done handshake. One multiplier bit is consumed per RUN cycle.
// Optional build macro SEQ_SHIFT_MULT_EARLY_TERM_EN: RUN ends as soon as the
// remaining multiplier bits are all zero (product unchanged, shorter latency).
module seq_shift_mult #(
   parameter int N = 16,
   parameter int C = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   In_A,
   input  logic [N-1:0]   In_B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] Prod
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [C-1:0] CNT_LAST = C'(N - 1);

   state_t         state;
   state_t         state_nx;
   logic [2*N-1:0] a;
   logic [2*N-1:0] acc;
   logic [N-1:0]   b;
   logic [C-1:0]   cnt;
   logic           last_iter;

   // Decide whether the current RUN iteration is the final one.
   always_comb begin
`ifdef SEQ_SHIFT_MULT_EARLY_TERM_EN
      last_iter = (cnt == CNT_LAST) || ((b >> 1) == '0);
`else
      last_iter = (cnt == CNT_LAST);
`endif
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last_iter) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: operand load, shift-and-add iterations, result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a    <= '0;
         b    <= '0;
         acc  <= '0;
         cnt  <= '0;
         Prod <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a   <= {{N{1'b0}}, In_A};
                  b   <= In_B;
                  acc <= '0;
                  cnt <= '0;
               end
            end
            RUN: begin
               if (b[0]) acc <= acc + a;
               a   <= a << 1;
               b   <= b >> 1;
               cnt <= cnt + 1'b1;
            end
            DONE: begin
               Prod <= acc;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // busy covers RUN and DONE.
   always_comb begin
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_seq_shift_mult.sv
// Scoreboard bench for seq_shift_mult: the driver predicts acceptance and
// timing from the handshake rules and pushes expected results; a monitor
// compares every done pulse (and busy every cycle) against the queue.
module tb_seq_shift_mult;
   localparam int N = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   in_a = '0;
   logic [N-1:0]   in_b = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] prod;

   seq_shift_mult #(.N(N), .C(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .In_A  (in_a),
      .In_B  (in_b),
      .busy  (busy),
      .done  (done),
      .Prod  (prod)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*N-1:0] prod;
      int             done_edge;
   } exp_t;

   exp_t sb[$];
   int   free_at  = 0;
   int   busy_lo  = 0;
   int   busy_hi  = -1;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
   endtask

   // Number of RUN cycles the multiply should take for multiplier b.
   function automatic int run_len(input logic [N-1:0] b);
      int msb_len = 1;
      int l;
      for (int i = 0; i < N; i++) if (b[i]) msb_len = i + 1;
`ifdef SEQ_SHIFT_MULT_EARLY_TERM_EN
      l = msb_len;
`else
      l = (msb_len > 0) ? N : N;
`endif
      return l;
   endfunction

   // One driven cycle: inputs change on the falling edge, model predicts the
   // effect of the following rising edge.
   task automatic cycle(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic r);
      int             ne;
      int             l;
      logic [2*N-1:0] wa;
      logic [2*N-1:0] wb;
      @(negedge clk);
      start = s;
      in_a  = a;
      in_b  = b;
      rst_n = r;
      ne    = cyc + 1;
      if (!r) begin
         sb.delete();
         busy_hi = -1;
         free_at = ne + 1;
      end else if (s && ne >= free_at) begin
         l  = run_len(b);
         wa = {{N{1'b0}}, a};
         wb = {{N{1'b0}}, b};
         sb.push_back('{prod: wa * wb, done_edge: ne + l + 1});
         busy_lo = ne;
         busy_hi = ne + l;
         free_at = ne + l + 2;
      end
   endtask

   task automatic wait_free();
      for (int i = 0; i < 100 && !(sb.size() == 0 && cyc + 1 >= free_at); i++)
         cycle(1'b0, '0, '0, 1'b1);
   endtask

   task automatic op(input logic [N-1:0] a, input logic [N-1:0] b);
      wait_free();
      cycle(1'b1, a, b, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
   endtask

   // Monitor: sample 1 time unit after each rising edge.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", done, 0);
         end else begin
            e = sb.pop_front();
            check("prod", prod, e.prod);
            check("done_latency", cyc, e.done_edge);
         end
      end else if (sb.size() > 0 && cyc >= sb[0].done_edge) begin
         e = sb.pop_front();
         check("done_missing", done, 1);
      end
      check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
   end

   initial begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      logic [N-1:0] mask;

      // Reset for two cycles, then check idle outputs.
      repeat (2) cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_prod", prod, 0);

      // Directed cases and boundaries.
      op(16'h0003, 16'h0005);
      op(16'hFFFF, 16'hFFFF);
      op(16'h1234, 16'h0000);
      op(16'h0000, 16'h1234);
      op(16'h1234, 16'h0001);
      op(16'h0055, 16'h0100);
      op(16'h8000, 16'h8000);

      // Start pulses during RUN are ignored.
      wait_free();
      cycle(1'b1, 16'h0002, 16'h0003, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b1, 16'h00FF, 16'h00FF, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b1, 16'h00FF, 16'h00FF, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);

      // Start held high with operands changing every cycle: back-to-back ops.
      wait_free();
      for (int i = 0; i < 60; i++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1);
      cycle(1'b0, '0, '0, 1'b1);

      // Reset at RUN cycle 7 abandons the multiply.
      wait_free();
      cycle(1'b1, 16'h0007, 16'h0009, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      check("midreset_busy", busy, 0);
      check("midreset_prod", prod, 0);
      op(16'h0004, 16'h0004);

      // Random operands with random multiplier widths and gaps.
      for (int i = 0; i < 30; i++) begin
         mask = 16'((32'h1 << $urandom_range(0, 16)) - 1);
         ra   = 16'($urandom);
         rb   = 16'($urandom) & mask;
         op(ra, rb);
         repeat ($urandom_range(0, 3)) cycle(1'b0, '0, '0, 1'b1);
      end

      wait_free();
      repeat (3) cycle(1'b0, '0, '0, 1'b1);
      if (sb.size() != 0) check("drain_queue", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
